if_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Directly upstream of ID: it consumes the hazard unit's stall signal and the ID-stage branch redirect, and it drives the synchronous instruction memory.
- Produces {pc, pc+4, instruction, valid} for ID.
- Keeps the fetch stream correct across stalls, even though IMEM read data lasts only one cycle.

---
 rtl/if_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch plus IF/ID register; captures the one-cycle IMEM word
// on a stall so no instruction is lost or duplicated. Define DELAY_SLOT_EN for a branch delay slot.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fl_pc_q, fl_pc_d;
    logic        fl_v_q, fl_v_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;

    logic        flush;
    logic        slot_v;
    logic [31:0] fw;

`ifdef DELAY_SLOT_EN
    assign flush = 1'b0;
`else
    // The in-flight fetch after a taken branch is wrong-path; squash it.
    assign flush = branch_taken_i;
`endif

    assign fw     = hold_v_q ? hold_q : imem_rdata_i;
    assign slot_v = fl_v_q && !flush;

    // NOTE: every always_comb output gets its default first so no path infers a latch.
    always_comb begin
        pc_d       = pc_q;
        fl_pc_d    = fl_pc_q;
        fl_v_d     = fl_v_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;

        if (!stall_i) begin
            id_pc_d    = fl_pc_q;
            id_inst_d  = slot_v ? fw : NOP_INST;
            id_valid_d = slot_v;
            fl_pc_d    = pc_q;
            fl_v_d     = 1'b1;
            pc_d       = branch_taken_i ? branch_target_i : pc_q + 32'd4;
            hold_v_d   = 1'b0;
        end else if (!hold_v_q) begin
            // Only the first stalled edge sees live IMEM data; later edges see a disabled RAM.
            hold_d   = imem_rdata_i;
            hold_v_d = fl_v_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    if (!stall_i) state_d = RUN;
            RUN:     if (stall_i)  state_d = HOLD;
            HOLD:    if (!stall_i) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            fl_pc_q    <= RESET_PC;
            fl_v_q     <= 1'b0;
            hold_q     <= 32'h0;
            hold_v_q   <= 1'b0;
            id_pc_q    <= 32'h0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fl_pc_q    <= fl_pc_d;
            fl_v_q     <= fl_v_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign imem_en_o   = !stall_i && rst_ni;
    assign imem_addr_o = pc_q;
    assign id_pc_o     = id_pc_q;
    assign id_pc4_o    = id_pc_q + 32'd4;
    assign id_inst_o   = id_inst_q;
    assign id_valid_o  = id_valid_q;

endmodule
